// File: rtl/mult_accum_if.sv
// Product-in / batch-sum-out bundle for the multiply-accumulate block.
// The master drives the product side and the downstream accept.
interface mult_accum_if #(
    parameter int WIDTH = 32
) ();
    localparam int ACCW = 2 * WIDTH + 8;

    logic signed [2*WIDTH-1:0] p;
    logic                      rdy;
    logic                      acc_clr;
    logic                      out_ready;
    logic signed [ACCW-1:0]    out_data;
    logic                      out_valid;
    logic                      ovf;
    logic                      busy;

    modport master (
        output p, rdy, acc_clr, out_ready,
        input  out_data, out_valid, ovf, busy
    );

    modport slave (
        input  p, rdy, acc_clr, out_ready,
        output out_data, out_valid, ovf, busy
    );
endinterface

// File: rtl/mult_accum.sv
// Sums ACC_N multiplier products per batch, with a one-deep output buffer
// so the next batch accumulates while the previous sum waits downstream.
module mult_accum #(
    parameter int WIDTH = 32,
    parameter int ACC_N = 4
) (
    input logic         clk,
    input logic         reset,
    mult_accum_if.slave bus
);
    localparam int ACCW = 2 * WIDTH + 8;
    localparam int CW   = $clog2(ACC_N + 1);
    localparam logic [CW-1:0] LAST = CW'(ACC_N - 1);

    logic                   rdy_q, rdy_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [ACCW-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;

    logic                   ev;
    logic                   done;
    logic signed [ACCW-1:0] sum;

    always_comb begin
        ev          = bus.rdy & ~rdy_q;
        sum         = acc_q + {{(ACCW-2*WIDTH){bus.p[2*WIDTH-1]}}, bus.p};
        done        = ev & ~bus.acc_clr & (cnt_q == LAST);
        rdy_d       = bus.rdy;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        ovf_d       = ovf_q;

        if (bus.acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (ev) begin
            if (cnt_q == LAST) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A full buffer that is not draining this edge drops the new sum.
        if (done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = sum;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: ACC_N=4 main instance plus an ACC_N=1
// instance fed the same products with its output never accepted.
module tb_mult_accum;
    localparam int WIDTH = 32;
    localparam int ACCW  = 2 * WIDTH + 8;

    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    mult_accum_if #(.WIDTH(WIDTH)) bus ();
    mult_accum_if #(.WIDTH(WIDTH)) b1 ();

    assign b1.p         = bus.p;
    assign b1.rdy       = bus.rdy;
    assign b1.acc_clr   = bus.acc_clr;
    assign b1.out_ready = 1'b0;

    mult_accum #(.WIDTH(WIDTH), .ACC_N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mult_accum #(.WIDTH(WIDTH), .ACC_N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    // Called at a negedge; the rising edge in between sees the rdy edge.
    task automatic pulse(input logic [2*WIDTH-1:0] v);
        bus.p   = v;
        bus.rdy = 1'b1;
        @(negedge clk);
        bus.rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.p         = '0;
        bus.rdy       = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.p         = 64'd7;
        bus.rdy       = 1'b1;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL reset_outputs: got v=%b d=%0d o=%b b=%b want all 0",
                     bus.out_valid, bus.out_data, bus.ovf, bus.busy);
            errs++;
        end
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL reset_first_event: busy got %b want 1", bus.busy);
            errs++;
        end
        bus.rdy = 1'b0;
        @(negedge clk);
        // Asynchronous assertion mid-cycle, checked before the next edge.
        #2 reset = 1'b1;
        #1;
        vecs++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset_async: busy got %b want 0", bus.busy);
            errs++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        pulse(64'd3);
        vecs++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== 72'sd3) begin
            $display("FAIL accn1_first: got v=%b d=%0d want v=1 d=3",
                     b1.out_valid, b1.out_data);
            errs++;
        end
        pulse(64'd5);
        pulse(64'hFFFF_FFFF_FFFF_FFFE);
        vecs++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL basic_partial: got b=%b v=%b want b=1 v=0",
                     bus.busy, bus.out_valid);
            errs++;
        end
        bus.p   = 64'd10;
        bus.rdy = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 72'sd16 ||
            bus.busy !== 1'b0) begin
            $display("FAIL basic_sum: got v=%b d=%0d b=%b want v=1 d=16 b=0",
                     bus.out_valid, bus.out_data, bus.busy);
            errs++;
        end
        bus.rdy = 1'b0;
        vecs++;
        if (b1.out_data !== 72'sd3 || b1.ovf !== 1'b1) begin
            $display("FAIL accn1_drop: got d=%0d o=%b want d=3 o=1",
                     b1.out_data, b1.ovf);
            errs++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL basic_accept: valid got %b want 0", bus.out_valid);
            errs++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_level();
        do_reset();
        bus.p   = 64'd9;
        bus.rdy = 1'b1;
        repeat (10) @(negedge clk);
        bus.rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) pulse(64'd1);
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 72'sd12 ||
            bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL level_sum: got v=%b d=%0d o=%b b=%b want v=1 d=12 o=0 b=0",
                     bus.out_valid, bus.out_data, bus.ovf, bus.busy);
            errs++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) pulse(64'd1);
        for (int i = 0; i < 4; i++) pulse(64'd2);
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 72'sd4 ||
            bus.ovf !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL bp_hold: got v=%b d=%0d o=%b b=%b want v=1 d=4 o=1 b=0",
                     bus.out_valid, bus.out_data, bus.ovf, bus.busy);
            errs++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b1) begin
            $display("FAIL bp_drain: got v=%b o=%b want v=0 o=1",
                     bus.out_valid, bus.ovf);
            errs++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) pulse(64'd1);
        for (int i = 0; i < 3; i++) pulse(64'd2);
        bus.p         = 64'd2;
        bus.rdy       = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.rdy       = 1'b0;
        bus.out_ready = 1'b0;
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 72'sd8 ||
            bus.ovf !== 1'b0) begin
            $display("FAIL b2b_reload: got v=%b d=%0d o=%b want v=1 d=8 o=0",
                     bus.out_valid, bus.out_data, bus.ovf);
            errs++;
        end
    endtask

    task automatic test_abort();
        do_reset();
        pulse(64'd100);
        pulse(64'd100);
        vecs++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL abort_busy: got %b want 1", bus.busy);
            errs++;
        end
        bus.p       = 64'd100;
        bus.rdy     = 1'b1;
        bus.acc_clr = 1'b1;
        @(negedge clk);
        bus.rdy     = 1'b0;
        bus.acc_clr = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            $display("FAIL abort_clear: got b=%b v=%b want b=0 v=0",
                     bus.busy, bus.out_valid);
            errs++;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) pulse(64'd1);
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 72'sd4 ||
            bus.ovf !== 1'b0) begin
            $display("FAIL abort_sum: got v=%b d=%0d o=%b want v=1 d=4 o=0",
                     bus.out_valid, bus.out_data, bus.ovf);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
